// File: rtl/lvds_idly_sched_if.sv
// Requester and IDELAYE3-facing signals of the IDELAY tap-update scheduler.
// The slave side is the scheduler. The master side is the lane engines plus the delay primitives.
interface lvds_idly_sched_if #(
    parameter int LANES    = 8,
    parameter int TAP_BITS = 9
);
    logic [LANES-1:0]          req;
    logic [TAP_BITS*LANES-1:0] req_tap;
    logic [LANES-1:0]          ack;
    logic [LANES-1:0]          err;
    logic [LANES-1:0]          idly_en_vtc;
    logic [LANES-1:0]          idly_load;
    logic [TAP_BITS*LANES-1:0] idly_cntvaluein;
    logic [TAP_BITS*LANES-1:0] idly_cntvalueout;

    modport master (
        output req, req_tap, idly_cntvalueout,
        input  ack, err, idly_en_vtc, idly_load, idly_cntvaluein
    );

    modport slave (
        input  req, req_tap, idly_cntvalueout,
        output ack, err, idly_en_vtc, idly_load, idly_cntvaluein
    );
endinterface

// File: rtl/lvds_idly_sched.sv
// Serialised, round-robin IDELAYE3 tap updater that follows the EN_VTC/LOAD/readback sequence.
// All outputs are registered. Each output reflects the state of the FSM in the same cycle.
module lvds_idly_sched #(
    parameter int LANES    = 8,
    parameter int TAP_BITS = 9,
    parameter int VTC_WAIT = 16,
    parameter int SETTLE   = 8
) (
    input  logic             idlyctrl_clk,
    input  logic             reset,
    input  logic             idlyctrl_rdy,
    output logic             ready,
    output logic             busy,
    lvds_idly_sched_if.slave bus
);
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CMAX = (VTC_WAIT > SETTLE) ? VTC_WAIT : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_WAIT_RDY, S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_VERIFY, S_VTC_ON
    } state_t;

    state_t                    state, state_nxt;
    logic                      rdy_meta, rdy_sync;
    logic [LANES-1:0]          pending, pending_nxt;
    logic [TAP_BITS-1:0]       tap [LANES];
    logic [TAP_BITS-1:0]       tap_nxt [LANES];
    logic [TAP_BITS-1:0]       work;
    logic [TAP_BITS-1:0]       readback;
    logic [LW-1:0]             ptr, grant_lane, lane_nxt;
    logic                      grant_found, grant, abort, busy_nxt;
    logic [CW-1:0]             cnt;
    logic [LANES-1:0]          en_vtc_q, load_q, ack_q, err_q;
    logic [LANES-1:0]          en_vtc_nxt, load_nxt, ack_nxt, err_nxt;
    logic [TAP_BITS*LANES-1:0] cntvaluein_q;

    assign readback             = bus.idly_cntvalueout[int'(ptr)*TAP_BITS +: TAP_BITS];
    assign bus.idly_en_vtc      = en_vtc_q;
    assign bus.idly_load        = load_q;
    assign bus.ack              = ack_q;
    assign bus.err              = err_q;
    assign bus.idly_cntvaluein  = cntvaluein_q;

    always_ff @(posedge idlyctrl_clk or posedge reset) begin
        if (reset) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
        end else begin
            rdy_meta <= idlyctrl_rdy;
            rdy_sync <= rdy_meta;
        end
    end

    // The search starts at the lane after the last grant, so every lane gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_lane  = ptr;
        for (int i = 1; i <= LANES; i++) begin
            if (!grant_found && pending[(int'(ptr) + i) % LANES]) begin
                grant_found = 1'b1;
                grant_lane  = LW'((int'(ptr) + i) % LANES);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        abort     = 1'b0;
        case (state)
            S_WAIT_RDY: if (rdy_sync) state_nxt = S_IDLE;
            S_IDLE: begin
                if (!rdy_sync) begin
                    state_nxt = S_WAIT_RDY;
                end else if (grant_found) begin
                    grant     = 1'b1;
                    state_nxt = S_VTC_OFF;
                end
            end
            S_VTC_OFF: if (cnt == CW'(VTC_WAIT - 1)) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_SETTLE;
            S_SETTLE:  if (cnt == CW'(SETTLE - 1)) state_nxt = S_VERIFY;
            S_VERIFY:  state_nxt = S_VTC_ON;
            S_VTC_ON:  state_nxt = rdy_sync ? S_IDLE : S_WAIT_RDY;
            default:   state_nxt = S_WAIT_RDY;
        endcase
        // Losing RDY mid-update abandons it and requeues the lane. The ack in VTC_ON has already gone out.
        if (!rdy_sync && (state inside {S_VTC_OFF, S_LOAD, S_SETTLE, S_VERIFY})) begin
            abort     = 1'b1;
            state_nxt = S_WAIT_RDY;
        end
    end

    always_comb begin
        lane_nxt   = grant ? grant_lane : ptr;
        busy_nxt   = state_nxt inside {S_VTC_OFF, S_LOAD, S_SETTLE, S_VERIFY};
        en_vtc_nxt = '1;
        load_nxt   = '0;
        ack_nxt    = '0;
        err_nxt    = '0;
        if (busy_nxt) en_vtc_nxt[lane_nxt] = 1'b0;
        if (state_nxt == S_LOAD) load_nxt[ptr] = 1'b1;
        if (state == S_VERIFY && state_nxt == S_VTC_ON) begin
            ack_nxt[ptr] = 1'b1;
            err_nxt[ptr] = (readback != work);
        end
    end

    // A fresh request always wins. An abort restores the working tap only if no newer tap is queued.
    always_comb begin
        pending_nxt = pending;
        for (int k = 0; k < LANES; k++) tap_nxt[k] = tap[k];
        if (grant) pending_nxt[grant_lane] = 1'b0;
        if (abort) begin
            if (!pending[ptr]) tap_nxt[ptr] = work;
            pending_nxt[ptr] = 1'b1;
        end
        for (int k = 0; k < LANES; k++) begin
            if (bus.req[k]) begin
                pending_nxt[k] = 1'b1;
                tap_nxt[k]     = bus.req_tap[k*TAP_BITS +: TAP_BITS];
            end
        end
    end

    always_ff @(posedge idlyctrl_clk or posedge reset) begin
        if (reset) begin
            state        <= S_WAIT_RDY;
            pending      <= '0;
            for (int k = 0; k < LANES; k++) tap[k] <= '0;
            work         <= '0;
            ptr          <= LW'(LANES - 1);
            cnt          <= '0;
            en_vtc_q     <= '1;
            load_q       <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            cntvaluein_q <= '0;
            busy         <= 1'b0;
            ready        <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            for (int k = 0; k < LANES; k++) tap[k] <= tap_nxt[k];
            if (grant) begin
                ptr  <= grant_lane;
                work <= tap[grant_lane];
            end
            if (state_nxt != state) cnt <= '0;
            else                    cnt <= cnt + 1'b1;
            if (state_nxt == S_LOAD) cntvaluein_q[int'(ptr)*TAP_BITS +: TAP_BITS] <= work;
            en_vtc_q <= en_vtc_nxt;
            load_q   <= load_nxt;
            ack_q    <= ack_nxt;
            err_q    <= err_nxt;
            busy     <= busy_nxt;
            ready    <= (state_nxt != S_WAIT_RDY);
        end
    end
endmodule

// File: tb/tb_lvds_idly_sched.sv
// Directed bench for lvds_idly_sched. It uses a scoreboard of expected acks and a loopback IDELAY model.
module tb_lvds_idly_sched;
    localparam int LANES    = 8;
    localparam int TAP_BITS = 9;

    typedef struct {
        int   lane;
        int   tap;
        logic err_bit;
    } exp_t;

    logic idlyctrl_clk = 1'b0;
    logic reset;
    logic idlyctrl_rdy;
    logic ready;
    logic busy;
    logic [LANES-1:0] stuck;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    lvds_idly_sched_if #(.LANES(LANES), .TAP_BITS(TAP_BITS)) bus ();

    lvds_idly_sched #(
        .LANES(LANES), .TAP_BITS(TAP_BITS), .VTC_WAIT(16), .SETTLE(8)
    ) dut (
        .idlyctrl_clk (idlyctrl_clk),
        .reset        (reset),
        .idlyctrl_rdy (idlyctrl_rdy),
        .ready        (ready),
        .busy         (busy),
        .bus          (bus)
    );

    always #5 idlyctrl_clk = ~idlyctrl_clk;
    always @(posedge idlyctrl_clk) cyc <= cyc + 1;

    // Loopback IDELAY model. A stuck lane reads back zero.
    for (genvar k = 0; k < LANES; k++) begin : g_loop
        assign bus.idly_cntvalueout[k*TAP_BITS +: TAP_BITS] =
            stuck[k] ? '0 : bus.idly_cntvaluein[k*TAP_BITS +: TAP_BITS];
    end

    task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge idlyctrl_clk);
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) step();
    endtask

    task automatic set_req(input int lane, input int tapv);
        bus.req[lane] = 1'b1;
        bus.req_tap[lane*TAP_BITS +: TAP_BITS] = TAP_BITS'(tapv);
    endtask

    task automatic push_exp(input int lane, input int tapv, input logic e);
        exp_t x;
        x.lane = lane; x.tap = tapv; x.err_bit = e;
        sb.push_back(x);
    endtask

    task automatic apply_stimulus(output int rc);
        rc = cyc;
        step();
        bus.req = '0;
    endtask

    task automatic apply_reset();
        bit up;
        reset   = 1'b1;
        bus.req = '0;
        sb.delete();
        step();
        step();
        check_output("rst_en_vtc", bus.idly_en_vtc, {LANES{1'b1}});
        check_output("rst_load", bus.idly_load, 0);
        check_output("rst_ack_err", {bus.ack, bus.err}, 0);
        check_output("rst_busy_ready", {busy, ready}, 0);
        check_output("rst_cntvaluein", bus.idly_cntvaluein, 0);
        reset = 1'b0;
        up = 1'b0;
        for (int i = 0; i < 10 && !up; i++) begin
            step();
            up = ready;
        end
        check_output("ready_after_reset", up, 1);
    endtask

    task automatic wait_ack(input string name, input int budget, output int at);
        exp_t e;
        bit seen;
        logic [LANES-1:0] m;
        seen = 1'b0;
        at   = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            check_output("vtc_single_lane", ($countones(~bus.idly_en_vtc) <= 1), 1);
            check_output("load_only_vtc_off", bus.idly_load & bus.idly_en_vtc, 0);
            if (bus.ack !== '0) begin
                seen = 1'b1;
                at   = cyc;
                if (sb.size() == 0) begin
                    check_output({name, "_unexpected_ack"}, bus.ack, 0);
                end else begin
                    e = sb.pop_front();
                    m = '0;
                    m[e.lane] = 1'b1;
                    check_output({name, "_ack_lane"}, bus.ack, m);
                    check_output({name, "_err"}, bus.err, e.err_bit ? m : '0);
                    check_output({name, "_tap"}, bus.idly_cntvaluein[e.lane*TAP_BITS +: TAP_BITS], e.tap);
                    check_output({name, "_vtc_back_on"}, bus.idly_en_vtc, {LANES{1'b1}});
                end
            end
        end
        check_output({name, "_ack_seen"}, seen, 1);
    endtask

    task automatic no_ack_for(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_output(name, bus.ack, 0);
        end
    endtask

    initial begin
        int rc, at, prev;
        reset            = 1'b1;
        idlyctrl_rdy     = 1'b1;
        stuck            = '0;
        bus.req          = '0;
        bus.req_tap      = '0;
        $display("[TB] start");
        apply_reset();

        // Single uncontended update on lane 0.
        set_req(0, 100);
        push_exp(0, 100, 1'b0);
        apply_stimulus(rc);
        check_output("t1_vtc_before_grant", bus.idly_en_vtc, {LANES{1'b1}});
        goto_cycle(rc + 2);
        check_output("t1_vtc_low", bus.idly_en_vtc, 8'hFE);
        check_output("t1_busy", busy, 1);
        goto_cycle(rc + 17);
        check_output("t1_no_early_load", bus.idly_load, 0);
        goto_cycle(rc + 18);
        check_output("t1_load", bus.idly_load, 8'h01);
        check_output("t1_cntvaluein", bus.idly_cntvaluein[TAP_BITS-1:0], 100);
        goto_cycle(rc + 19);
        check_output("t1_load_one_cycle", bus.idly_load, 0);
        goto_cycle(rc + 27);
        check_output("t1_vtc_still_low", bus.idly_en_vtc, 8'hFE);
        wait_ack("t1", 5, at);
        check_output("t1_latency", at - rc, 28);
        check_output("t1_busy_clear", busy, 0);

        // All lanes at once, from reset, so lane 0 is first.
        apply_reset();
        for (int k = 0; k < LANES; k++) begin
            set_req(k, 200 + 5 * k);
            push_exp(k, 200 + 5 * k, 1'b0);
        end
        apply_stimulus(rc);
        for (int k = 0; k < LANES; k++) begin
            wait_ack("t2_all", 40, at);
            check_output("t2_ack_time", at - rc, 28 * (k + 1));
        end
        set_req(3, 303);
        set_req(1, 101);
        push_exp(1, 101, 1'b0);
        push_exp(3, 303, 1'b0);
        apply_stimulus(rc);
        wait_ack("t2_pair_first", 40, at);
        check_output("t2_pair_first_time", at - rc, 28);
        prev = at;
        wait_ack("t2_pair_second", 40, at);
        check_output("t2_pair_spacing", at - prev, 28);

        // Readback mismatch on lane 2.
        stuck[2] = 1'b1;
        set_req(2, 50);
        push_exp(2, 50, 1'b1);
        apply_stimulus(rc);
        wait_ack("t3_mismatch", 40, at);
        stuck = '0;

        // Lane 4 is re-requested while it is in service.
        set_req(4, 10);
        push_exp(4, 10, 1'b0);
        apply_stimulus(rc);
        goto_cycle(rc + 6);
        set_req(4, 20);
        push_exp(4, 20, 1'b0);
        apply_stimulus(prev);
        wait_ack("t4_first", 40, at);
        check_output("t4_first_time", at - rc, 28);
        prev = at;
        wait_ack("t4_second", 40, at);
        check_output("t4_second_spacing", at - prev, 28);

        // RDY drops during SETTLE, then comes back.
        set_req(5, 77);
        push_exp(5, 77, 1'b0);
        apply_stimulus(rc);
        goto_cycle(rc + 20);
        idlyctrl_rdy = 1'b0;
        no_ack_for("t5_no_ack_abort", 3);
        check_output("t5_vtc_restored", bus.idly_en_vtc, {LANES{1'b1}});
        check_output("t5_load_low", bus.idly_load, 0);
        check_output("t5_busy_ready", {busy, ready}, 0);
        no_ack_for("t5_no_ack_while_down", 10);
        idlyctrl_rdy = 1'b1;
        wait_ack("t5_retry", 80, at);

        // Reset arrives during VTC_OFF.
        set_req(6, 33);
        apply_stimulus(rc);
        goto_cycle(rc + 6);
        check_output("t6_in_service", bus.idly_en_vtc[6], 0);
        reset = 1'b1;
        #1;
        check_output("t6_rst_en_vtc", bus.idly_en_vtc, {LANES{1'b1}});
        check_output("t6_rst_busy_ack", {busy, bus.ack, bus.idly_load}, 0);
        check_output("t6_rst_cntvaluein", bus.idly_cntvaluein, 0);
        step();
        reset = 1'b0;
        no_ack_for("t6_no_ack_after_reset", 60);
        check_output("t6_ready_again", ready, 1);
        check_output("t6_scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
